// File: rtl/ppwm_pkg.sv
// Shared types for the ppwm instruction executors: opcodes, control sub-codes,
// FSM states and compare-source selectors.
package ppwm_pkg;

  typedef enum logic [2:0] {
    OP_CTRL   = 3'd0,
    OP_SET    = 3'd1,
    OP_ARITH  = 3'd2,
    OP_SHIFT  = 3'd3,
    OP_JUMP   = 3'd4,
    OP_CMP    = 3'd5,
    OP_MV     = 3'd6,
    OP_BRANCH = 3'd7
  } ex_multi_op_e;

  typedef enum logic [1:0] {
    CTRL_NOP  = 2'd0,
    CTRL_WAIT = 2'd1,
    CTRL_HALT = 2'd2
  } ex_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2
  } ex_multi_state_e;

  typedef enum logic [1:0] {
    CMP_GCNT_LO = 2'd0,
    CMP_GCNT_HI = 2'd1,
    CMP_REG0    = 2'd2,
    CMP_NONE    = 2'd3
  } cmp_src_e;

  // Operand selector width; a single operand still needs one select bit.
  function automatic int sel_width(input int n_ops);
    return (n_ops < 2) ? 1 : $clog2(n_ops);
  endfunction

endpackage

// File: rtl/ppwm_operand_file.sv
// Channel values followed by scratch registers in one word array.
// Two combinational read ports (target T, source S) and one write port.
module ppwm_operand_file
  import ppwm_pkg::*;
#(
  parameter int W        = 10,
  parameter int NUM_CH   = 2,
  parameter int NUM_REGS = 2,
  parameter int AW       = sel_width(NUM_CH + NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       t_addr,
  input  logic [AW-1:0]       s_addr,
  input  logic                we,
  input  logic [AW-1:0]       w_addr,
  input  logic [W-1:0]        w_data,
  output logic [W-1:0]        t_data,
  output logic [W-1:0]        s_data,
  output logic [NUM_CH*W-1:0] ch_values
);

  localparam int N = NUM_CH + NUM_REGS;

  logic [W-1:0] mem [N];

  // Addresses past the last word read as zero and swallow writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we && (32'(w_addr) < N)) begin
      mem[w_addr] <= w_data;
    end
  end

  assign t_data = (32'(t_addr) < N) ? mem[t_addr] : '0;
  assign s_data = (32'(s_addr) < N) ? mem[s_addr] : '0;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_values[k*W +: W] = mem[k];
  end

endmodule

// File: rtl/ppwm_ex_multi.sv
// Multi-channel ppwm instruction executor: fetch/decode/execute one instruction
// per cycle, with jumps, branches, WAIT/HALT, a step watchdog and overrun flag.
module ppwm_ex_multi
  import ppwm_pkg::*;
#(
  parameter int COUNTER_WIDTH        = 10,
  parameter int GLOBAL_COUNTER_WIDTH = 20,
  parameter int NUM_CH               = 2,
  parameter int NUM_REGS             = 2,
  parameter int INSTR_WIDTH          = 10,
  parameter int PC_WIDTH             = 5,
  parameter int MAX_STEPS            = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic [GLOBAL_COUNTER_WIDTH-1:0] global_counter_i,
  input  logic [INSTR_WIDTH-1:0]          instr_i,
  output logic [PC_WIDTH-1:0]             pc_o,
  output logic [NUM_CH*COUNTER_WIDTH-1:0] pwm_value_o,
  output logic                            busy_o,
  output logic                            overrun_o,
  output logic                            timeout_o,
  output ex_multi_state_e                 state_o
);

  localparam int CW     = COUNTER_WIDTH;
  localparam int SEL_W  = sel_width(NUM_CH + NUM_REGS);
  localparam int IMM_W  = INSTR_WIDTH - 3 - SEL_W;
  localparam int OFF_W  = SEL_W + IMM_W;
  localparam int STEP_W = $clog2(MAX_STEPS);

  ex_multi_state_e    state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               flag_q, flag_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;

  // Decode fields
  ex_multi_op_e             op;
  logic [SEL_W-1:0]         sel;
  logic [IMM_W-1:0]         imm;
  logic signed [IMM_W-1:0]  imm_s;
  logic signed [OFF_W-1:0]  off;
  logic [CW-1:0]            imm_zext, imm_sext;
  logic [PC_WIDTH-1:0]      pc_rel;
  logic [CW-1:0]            gcnt_lo, gcnt_hi;

  assign op       = ex_multi_op_e'(instr_i[2:0]);
  assign sel      = instr_i[3 +: SEL_W];
  assign imm      = instr_i[INSTR_WIDTH-1 -: IMM_W];
  assign imm_s    = imm;
  assign off      = {sel, imm};
  assign imm_zext = CW'(imm);
  assign imm_sext = CW'(imm_s);
  assign pc_rel   = pc_q + PC_WIDTH'(off);
  assign gcnt_lo  = global_counter_i[CW-1:0];
  assign gcnt_hi  = CW'(global_counter_i[GLOBAL_COUNTER_WIDTH-1:CW]);

  // Operand file interface
  logic [SEL_W-1:0] s_addr;
  logic             we;
  logic [CW-1:0]    w_data, t_data, s_data;
  logic             jump_taken;

  ppwm_operand_file #(
    .W        (CW),
    .NUM_CH   (NUM_CH),
    .NUM_REGS (NUM_REGS),
    .AW       (SEL_W)
  ) u_operands (
    .clk       (clk),
    .rst_n     (rst_n),
    .t_addr    (sel),
    .s_addr    (s_addr),
    .we        (we),
    .w_addr    (sel),
    .w_data    (w_data),
    .t_data    (t_data),
    .s_data    (s_data),
    .ch_values (pwm_value_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      step_q    <= '0;
      flag_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      step_q    <= step_d;
      flag_q    <= flag_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    step_d     = step_q;
    flag_d     = flag_q;
    overrun_d  = 1'b0;
    timeout_d  = 1'b0;
    we         = 1'b0;
    w_data     = t_data;
    s_addr     = SEL_W'(NUM_CH);
    jump_taken = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (start_i) begin
          state_d = ST_EXEC;
          step_d  = '0;
        end
      end
      ST_EXEC: begin
        overrun_d = start_i;
        step_d    = step_q + STEP_W'(1);
        pc_d      = pc_q + PC_WIDTH'(1);
        unique case (op)
          OP_CTRL: begin
            if (imm == IMM_W'(CTRL_WAIT)) begin
              state_d = ST_WAIT;
            end else if (imm == IMM_W'(CTRL_HALT)) begin
              state_d = ST_IDLE;
              pc_d    = '0;
            end
          end
          OP_SET: begin
            we     = 1'b1;
            w_data = imm_zext;
          end
          OP_ARITH: begin
            we     = 1'b1;
            w_data = t_data + imm_sext;
          end
          OP_SHIFT: begin
            we     = 1'b1;
            w_data = imm[0] ? (t_data << 1) : (t_data >> 1);
          end
          OP_JUMP: begin
            jump_taken = 1'b1;
            pc_d       = pc_rel;
          end
          OP_CMP: begin
            unique case (cmp_src_e'(imm[1:0]))
              CMP_GCNT_LO: flag_d = gcnt_lo < t_data;
              CMP_GCNT_HI: flag_d = gcnt_hi < t_data;
              CMP_REG0:    flag_d = s_data < t_data;
              CMP_NONE:    flag_d = 1'b0;
            endcase
          end
          OP_MV: begin
            we = 1'b1;
            if (imm[IMM_W-1]) begin
              w_data = imm[0] ? gcnt_hi : gcnt_lo;
            end else begin
              s_addr = imm[SEL_W-1:0];
              w_data = s_data;
            end
          end
          OP_BRANCH: begin
            if (flag_q) begin
              jump_taken = 1'b1;
              pc_d       = pc_rel;
            end
          end
        endcase
        // Falling off the last address ends the program; pc_d has already wrapped to 0.
        if ((pc_q == '1) && !jump_taken) state_d = ST_IDLE;
        // Watchdog has the final word over WAIT, jumps and end-of-program.
        if (step_q == STEP_W'(MAX_STEPS - 1)) begin
          state_d   = ST_IDLE;
          pc_d      = '0;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pc_o      = pc_q;
  assign busy_o    = (state_q == ST_EXEC);
  assign overrun_o = overrun_q;
  assign timeout_o = timeout_q;
  assign state_o   = state_q;

endmodule
